// File: rtl/spart_pkg.sv
// spart_pkg: shared definitions for the SPART bus slave.
// Holds register offsets, status bit positions, FSM state encodings and
// the baud divisor helper.
package spart_pkg;

    // Register offsets from BASE_ADDR
    localparam int unsigned TX_OFF   = 0;
    localparam int unsigned RX_OFF   = 1;
    localparam int unsigned STAT_OFF = 2;

    // Status register bit positions
    localparam int unsigned STAT_RX_VALID  = 0;
    localparam int unsigned STAT_TX_BUSY   = 1;
    localparam int unsigned STAT_OVERRUN   = 2;
    localparam int unsigned STAT_FRAME_ERR = 3;
    localparam int unsigned STAT_W         = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per bit, rounded to nearest
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/spart_fifo.sv
// spart_fifo: synchronous FIFO for received bytes.
// Ports: clk, rst_n (async active-low), push/din write side, pop read side,
// full/empty flags and head (oldest entry, valid when not empty).
// A push while full is dropped unless a pop happens in the same cycle.
module spart_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spart_bus_slave.sv
// spart_bus_slave: memory-mapped UART on the processor bus.
// Registers: BASE+0 TX data (write), BASE+1 RX data (read, stalls while
// empty), BASE+2 status {frame_err, overrun, tx_busy, rx_valid}.
// Ports: clk, rst_n (async active-low), bus_write/bus_read/bus_addr/bus_wdata
// request, bus_rdata/bus_ack combinational response, rxd serial in, txd out.
// Build option: define SPART_LOOPBACK_EN to feed the receiver from txd.
module spart_bus_slave
    import spart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000001C,
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    input  logic        rxd,
    output logic        txd
);

    localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);

    if (DIV < 4) begin : g_div_chk
        $error("spart_bus_slave: baud divisor %0d is below 4", DIV);
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("spart_bus_slave: FIFO_DEPTH %0d must be a power of 2 and >= 2", FIFO_DEPTH);
    end

    // ---------------- declarations ----------------
    logic              sel_tx, sel_rx, sel_st;
    logic              hold_load_c, fifo_pop_c, stat_clr_c;
    logic              fifo_full, fifo_empty;
    logic [7:0]        fifo_head;
    logic [STAT_W-1:0] status_c;
    logic              unused_wdata;

    tx_state_t         tx_state, tx_state_nxt;
    logic [CNT_W-1:0]  tx_cnt, tx_cnt_nxt;
    logic [2:0]        tx_bit, tx_bit_nxt;
    logic [7:0]        tx_shift, tx_shift_nxt;
    logic              hold_full, hold_full_nxt;
    logic [7:0]        hold_data, hold_data_nxt;
    logic              txd_nxt;

    rx_state_t         rx_state, rx_state_nxt;
    logic [CNT_W-1:0]  rx_cnt, rx_cnt_nxt;
    logic [2:0]        rx_bit, rx_bit_nxt;
    logic [7:0]        rx_shift, rx_shift_nxt;
    logic              rx_in, rx_meta, rx_s, rx_prev;
    logic              rx_push_c, frame_err_set_c, overrun_set_c;
    logic              overrun_q, frame_err_q;

    assign unused_wdata = ^bus_wdata[31:8];

`ifdef SPART_LOOPBACK_EN
    logic unused_rxd;
    assign unused_rxd = rxd;
    assign rx_in      = txd;
`else
    assign rx_in = rxd;
`endif

    // ---------------- bus decode and response ----------------
    assign sel_tx = (bus_addr == BASE_ADDR + 32'(TX_OFF));
    assign sel_rx = (bus_addr == BASE_ADDR + 32'(RX_OFF));
    assign sel_st = (bus_addr == BASE_ADDR + 32'(STAT_OFF));

    always_comb begin
        status_c                 = '0;
        status_c[STAT_RX_VALID]  = !fifo_empty;
        status_c[STAT_TX_BUSY]   = (tx_state != TX_IDLE) || hold_full;
        status_c[STAT_OVERRUN]   = overrun_q;
        status_c[STAT_FRAME_ERR] = frame_err_q;
    end

    // Write wins if both requests are asserted
    always_comb begin
        bus_ack     = 1'b0;
        bus_rdata   = '0;
        hold_load_c = 1'b0;
        fifo_pop_c  = 1'b0;
        stat_clr_c  = 1'b0;
        if (bus_write) begin
            if (sel_tx) begin
                if (!hold_full) begin
                    bus_ack     = 1'b1;
                    hold_load_c = 1'b1;
                end
            end else if (sel_rx || sel_st) begin
                bus_ack = 1'b1;
            end
        end else if (bus_read) begin
            if (sel_tx) begin
                bus_ack = 1'b1;
            end else if (sel_rx) begin
                if (!fifo_empty) begin
                    bus_ack    = 1'b1;
                    bus_rdata  = {24'b0, fifo_head};
                    fifo_pop_c = 1'b1;
                end
            end else if (sel_st) begin
                bus_ack    = 1'b1;
                bus_rdata  = {28'b0, status_c};
                stat_clr_c = 1'b1;
            end
        end
    end

    // ---------------- transmitter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            hold_full <= 1'b0;
            hold_data <= '0;
            txd       <= 1'b1;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_cnt    <= tx_cnt_nxt;
            tx_bit    <= tx_bit_nxt;
            tx_shift  <= tx_shift_nxt;
            hold_full <= hold_full_nxt;
            hold_data <= hold_data_nxt;
            txd       <= txd_nxt;
        end
    end

    // Holding register refills the shifter straight from STOP, so frames abut
    always_comb begin
        tx_state_nxt  = tx_state;
        tx_cnt_nxt    = tx_cnt;
        tx_bit_nxt    = tx_bit;
        tx_shift_nxt  = tx_shift;
        hold_full_nxt = hold_full;
        hold_data_nxt = hold_data;
        txd_nxt       = 1'b1;
        if (hold_load_c) begin
            hold_full_nxt = 1'b1;
            hold_data_nxt = bus_wdata[7:0];
        end
        case (tx_state)
            TX_IDLE: begin
                if (hold_full) begin
                    tx_state_nxt  = TX_START;
                    tx_shift_nxt  = hold_data;
                    hold_full_nxt = 1'b0;
                    tx_cnt_nxt    = '0;
                end
            end
            TX_START: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
                    else                tx_bit_nxt   = tx_bit + 3'd1;
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nxt = '0;
                    if (hold_full) begin
                        tx_state_nxt  = TX_START;
                        tx_shift_nxt  = hold_data;
                        hold_full_nxt = 1'b0;
                    end else begin
                        tx_state_nxt = TX_IDLE;
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt + CNT_W'(1);
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
        // Line level follows the next state so txd is a clean flop output
        case (tx_state_nxt)
            TX_START: txd_nxt = 1'b0;
            TX_DATA:  txd_nxt = tx_shift_nxt[0];
            default:  txd_nxt = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta     <= rx_in;
            rx_s        <= rx_meta;
            rx_prev     <= rx_s;
            rx_state    <= rx_state_nxt;
            rx_cnt      <= rx_cnt_nxt;
            rx_bit      <= rx_bit_nxt;
            rx_shift    <= rx_shift_nxt;
            // A new event in the clearing cycle is kept
            overrun_q   <= (overrun_q && !stat_clr_c) || overrun_set_c;
            frame_err_q <= (frame_err_q && !stat_clr_c) || frame_err_set_c;
        end
    end

    assign overrun_set_c = rx_push_c && fifo_full && !fifo_pop_c;

    always_comb begin
        rx_state_nxt    = rx_state;
        rx_cnt_nxt      = rx_cnt;
        rx_bit_nxt      = rx_bit;
        rx_shift_nxt    = rx_shift;
        rx_push_c       = 1'b0;
        frame_err_set_c = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                // Mid-bit recheck rejects glitches shorter than half a bit
                if (rx_cnt == CNT_HALF) begin
                    rx_cnt_nxt = '0;
                    rx_bit_nxt = '0;
                    rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_s, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
                    else                rx_bit_nxt   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = RX_IDLE;
                    if (rx_s) rx_push_c       = 1'b1;
                    else      frame_err_set_c = 1'b1;
                end else begin
                    rx_cnt_nxt = rx_cnt + CNT_W'(1);
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    spart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push_c),
        .pop   (fifo_pop_c),
        .din   (rx_shift),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

endmodule

// File: tb/tb_spart_bus_slave.sv
// tb_spart_bus_slave: directed bench for spart_bus_slave with DIV = 4.
module tb_spart_bus_slave;

    localparam logic [31:0] BASE = 32'h4000001C;
    localparam logic [31:0] RXA  = 32'h4000001D;
    localparam logic [31:0] STA  = 32'h4000001E;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_write = 1'b0;
    logic        bus_read = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        rxd = 1'b1;
    logic        txd;

    int checks = 0;
    int errors = 0;

    spart_bus_slave #(
        .BASE_ADDR  (BASE),
        .CLK_HZ     (400),
        .BAUD       (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_write (bus_write),
        .bus_read  (bus_read),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .rxd       (rxd),
        .txd       (txd)
    );

    always #5 clk = ~clk;

    task automatic idle_bus();
        bus_write = 1'b0;
        bus_read  = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
    endtask

    // Drive one 10-bit frame on rxd, 4 cycles per bit
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rxd = f[i/4];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_bus();
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
        checks++;
        if (bus_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus_ack); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read = 1'b1;
        bus_addr = STA;
        #1;
        checks++;
        if (bus_ack !== 1'b1 || bus_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: got ack=%b rdata=%h expected ack=1 rdata=00000000", bus_ack, bus_rdata);
        end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic test_decode();
        logic [31:0] addrs [6];
        logic        wr    [6];
        logic        eack  [6];
        addrs = '{32'h4000001F, 32'h4000001B, BASE, RXA, STA, 32'h4000011C};
        wr    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        eack  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus_addr  = addrs[i];
            bus_write = wr[i];
            bus_read  = !wr[i];
            bus_wdata = 32'hA5;
            #1;
            checks++;
            if (bus_ack !== eack[i] || bus_rdata !== 32'h0) begin
                errors++;
                $display("FAIL decode_%0d: got ack=%b rdata=%h expected ack=%b rdata=00000000",
                         i, bus_ack, bus_rdata, eack[i]);
            end
            @(negedge clk);
            idle_bus();
        end
        // None of the above may have started a frame
        repeat (3) @(negedge clk);
        bus_read = 1'b1;
        bus_addr = STA;
        #1;
        checks++;
        if (txd !== 1'b1 || bus_rdata !== 32'h0) begin
            errors++;
            $display("FAIL decode_no_effect: got txd=%b status=%h expected txd=1 status=00000000", txd, bus_rdata);
        end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic test_tx();
        logic [9:0] f;
        f = {1'b1, 8'h42, 1'b0};
        @(negedge clk);
        bus_write = 1'b1;
        bus_addr  = BASE;
        bus_wdata = 32'hFFFF_FF42;
        #1;
        checks++;
        if (bus_ack !== 1'b1) begin errors++; $display("FAIL tx_ack: got %b expected 1", bus_ack); end
        @(negedge clk);
        idle_bus();
        #1;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL tx_pre_start: got %b expected 1", txd); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 20) begin
                bus_read = 1'b1;
                bus_addr = STA;
            end else begin
                idle_bus();
            end
            #1;
            checks++;
            if (txd !== f[i/4]) begin
                errors++;
                $display("FAIL tx_bit_c%0d: got %b expected %b", i, txd, f[i/4]);
            end
            if (i == 20) begin
                checks++;
                if (bus_ack !== 1'b1 || bus_rdata !== 32'h2) begin
                    errors++;
                    $display("FAIL tx_busy_status: got ack=%b rdata=%h expected ack=1 rdata=00000002", bus_ack, bus_rdata);
                end
            end
        end
        @(negedge clk);
        idle_bus();
        bus_read = 1'b1;
        bus_addr = STA;
        #1;
        checks++;
        if (txd !== 1'b1 || bus_rdata !== 32'h0) begin
            errors++;
            $display("FAIL tx_done: got txd=%b status=%h expected txd=1 status=00000000", txd, bus_rdata);
        end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic test_back_to_back();
        logic [9:0] f1, f2;
        logic       exp;
        int         ack_cyc;
        f1 = {1'b1, 8'h49, 1'b0};
        f2 = {1'b1, 8'h41, 1'b0};
        ack_cyc = -1;
        @(negedge clk);
        bus_write = 1'b1;
        bus_addr  = BASE;
        bus_wdata = 32'h49;
        #1;
        checks++;
        if (bus_ack !== 1'b1) begin errors++; $display("FAIL b2b_first_ack: got %b expected 1", bus_ack); end
        for (int i = 1; i <= 82; i++) begin
            @(negedge clk);
            if (i == 1) bus_wdata = 32'h41;
            if (ack_cyc >= 0) idle_bus();
            #1;
            if (bus_write && bus_ack && ack_cyc < 0) ack_cyc = i;
            if (i >= 2) begin
                if (i - 2 < 40)      exp = f1[(i-2)/4];
                else if (i - 2 < 80) exp = f2[(i-42)/4];
                else                 exp = 1'b1;
                checks++;
                if (txd !== exp) begin
                    errors++;
                    $display("FAIL b2b_bit_c%0d: got %b expected %b", i, txd, exp);
                end
            end
        end
        idle_bus();
        checks++;
        if (ack_cyc < 1 || ack_cyc > 2) begin
            errors++;
            $display("FAIL b2b_second_ack: got cycle %0d expected 1..2", ack_cyc);
        end
    endtask

    task automatic test_rx_stall();
        logic [9:0] f;
        logic       early;
        logic       got;
        f = {1'b1, 8'h5A, 1'b0};
        early = 1'b0;
        got = 1'b0;
        @(negedge clk);
        bus_read = 1'b1;
        bus_addr = RXA;
        #1;
        checks++;
        if (bus_ack !== 1'b0) begin errors++; $display("FAIL rx_empty_stall: got ack=%b expected 0", bus_ack); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rxd = f[i/4];
            #1;
            if (bus_ack) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin errors++; $display("FAIL rx_early_ack: got %b expected 0", early); end
        for (int j = 0; j < 12 && !got; j++) begin
            @(negedge clk);
            rxd = 1'b1;
            #1;
            if (bus_ack) begin
                got = 1'b1;
                checks++;
                if (bus_rdata !== 32'h0000005A) begin
                    errors++;
                    $display("FAIL rx_data: got %h expected 0000005a", bus_rdata);
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL rx_ack_timeout: got no ack expected ack within 12 cycles");
        end
        @(negedge clk);
        bus_addr = STA;
        #1;
        checks++;
        if (bus_rdata !== 32'h0) begin errors++; $display("FAIL rx_drained: got %h expected 00000000", bus_rdata); end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic test_overrun();
        for (int k = 0; k < 5; k++) send_byte(8'(k + 1), 1'b1);
        @(negedge clk);
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        bus_read = 1'b1;
        bus_addr = RXA;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++;
            if (bus_ack !== 1'b1 || bus_rdata !== 32'(k + 1)) begin
                errors++;
                $display("FAIL ovr_read_%0d: got ack=%b rdata=%h expected ack=1 rdata=%h",
                         k, bus_ack, bus_rdata, 32'(k + 1));
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus_ack !== 1'b0) begin errors++; $display("FAIL ovr_fifo_empty: got ack=%b expected 0", bus_ack); end
        @(negedge clk);
        bus_addr = STA;
        #1;
        checks++;
        if (bus_rdata !== 32'h4) begin errors++; $display("FAIL ovr_status: got %h expected 00000004", bus_rdata); end
        @(negedge clk);
        #1;
        checks++;
        if (bus_rdata !== 32'h0) begin errors++; $display("FAIL ovr_cleared: got %h expected 00000000", bus_rdata); end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic test_frame_err();
        send_byte(8'h33, 1'b0);
        @(negedge clk);
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        bus_read = 1'b1;
        bus_addr = STA;
        #1;
        checks++;
        if (bus_rdata !== 32'h8) begin errors++; $display("FAIL ferr_status: got %h expected 00000008", bus_rdata); end
        @(negedge clk);
        bus_addr = RXA;
        #1;
        checks++;
        if (bus_ack !== 1'b0) begin errors++; $display("FAIL ferr_no_push: got ack=%b expected 0", bus_ack); end
        @(negedge clk);
        bus_addr = STA;
        #1;
        checks++;
        if (bus_rdata !== 32'h0) begin errors++; $display("FAIL ferr_cleared: got %h expected 00000000", bus_rdata); end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic test_glitch();
        logic got;
        got = 1'b0;
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (50) @(negedge clk);
        bus_read = 1'b1;
        bus_addr = STA;
        #1;
        checks++;
        if (bus_rdata !== 32'h0) begin errors++; $display("FAIL glitch_status: got %h expected 00000000", bus_rdata); end
        @(negedge clk);
        bus_addr = RXA;
        #1;
        checks++;
        if (bus_ack !== 1'b0) begin errors++; $display("FAIL glitch_no_push: got ack=%b expected 0", bus_ack); end
        @(negedge clk);
        idle_bus();
        send_byte(8'hA5, 1'b1);
        bus_read = 1'b1;
        bus_addr = RXA;
        for (int j = 0; j < 12 && !got; j++) begin
            @(negedge clk);
            rxd = 1'b1;
            #1;
            if (bus_ack) begin
                got = 1'b1;
                checks++;
                if (bus_rdata !== 32'h000000A5) begin
                    errors++;
                    $display("FAIL glitch_next_byte: got %h expected 000000a5", bus_rdata);
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL glitch_next_timeout: got no ack expected ack within 12 cycles");
        end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic test_reset_midframe();
        logic stuck;
        stuck = 1'b0;
        @(negedge clk);
        bus_write = 1'b1;
        bus_addr  = BASE;
        bus_wdata = 32'h00;
        @(negedge clk);
        idle_bus();
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL midframe_low: got %b expected 0", txd); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL midframe_abort: got %b expected 1", txd); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            #1;
            if (txd !== 1'b1) stuck = 1'b1;
        end
        checks++;
        if (stuck !== 1'b0) begin errors++; $display("FAIL midframe_no_resume: got %b expected 0", stuck); end
        bus_read = 1'b1;
        bus_addr = STA;
        #1;
        checks++;
        if (bus_rdata !== 32'h0) begin errors++; $display("FAIL midframe_status: got %h expected 00000000", bus_rdata); end
        @(negedge clk);
        idle_bus();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_tx();
        test_back_to_back();
        test_rx_stall();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
